// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory with a zeroing sweep after reset,
// programmable access latency, a Ready handshake and alignment/range fault
// detection. Loads sign- or zero-extend; stores merge bytes into the
// addressed word. Little-endian: lane 0 is bits 7:0.
module dmem_ctrl #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Fault,
    output logic        Busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic          fault_c;
    logic          do_access;
    logic          mem_we;
    logic [3:0]    be;
    logic [31:0]   wr_lanes;
    logic [31:0]   merged;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_val;

    assign word_idx  = addr_q[AW+1:2];
    assign cur_word  = mem[word_idx];
    assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Any bit above the last word's byte address means out of range.
    assign fault_c = (rd_q & wr_q)
                   | (size_q == 2'b11)
                   | ((size_q == 2'b01) & addr_q[0])
                   | ((size_q == 2'b10) & (|addr_q[1:0]))
                   | (|addr_q[31:AW+2]);

    assign mem_we = do_access && wr_q && !fault_c;

    // Byte enables and lane-replicated store data for the latched store size.
    always_comb begin
        be       = 4'b1111;
        wr_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                be       = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wr_lanes = wdata_q;
            end
        endcase
    end

    // Each byte lane either takes the new store data or keeps the old word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = be[gi] ? wr_lanes[8*gi +: 8] : cur_word[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = cur_word[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = cur_word[{addr_q[1], 4'b0000} +: 16];

    // Extract the addressed field and extend it to 32 bits.
    always_comb begin
        ld_val = cur_word;
        case (size_q)
            2'b00:   ld_val = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = cur_word;
        endcase
    end

    // Next-state logic: sweep, request capture, latency countdown, response.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            S_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (MemRead | MemWrite) begin
                    addr_d  = Address;
                    wdata_d = WriteData;
                    size_d  = Size;
                    uns_d   = Unsigned;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    cnt_d   = 4'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    fault_d = fault_c;
                    rdata_d = (fault_c || wr_q) ? 32'd0 : ld_val;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Control and result registers; reset restarts the clearing sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Storage array: zeroed word by word during the sweep, merged on stores.
    // Reset forces the state to INIT at once, so a dropped store never writes.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[idx_q] <= 32'd0;
        end else if (mem_we) begin
            mem[word_idx] <= merged;
        end
    end

    assign Ready    = (state_q == S_RESP);
    assign Fault    = (state_q == S_RESP) & fault_q;
    assign Busy     = (state_q == S_INIT);
    assign ReadData = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: two instances (DEPTH=128/LATENCY=2 and
// DEPTH=16/LATENCY=0) checked against a byte-array reference model.
module tb_dmem_ctrl;

    localparam int DEP_A = 128;
    localparam int LAT_A = 2;
    localparam int DEP_B = 16;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [1:0]  sz    [2];
    logic        uns   [2];
    logic [31:0] rdat  [2];
    logic        rdy   [2];
    logic        flt   [2];
    logic        bsy   [2];

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mdl [2][512];
    bit          chained [2];

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEP_A), .LATENCY(LAT_A)) u_a (
        .clk(clk), .reset(rst[0]), .Address(addr[0]), .WriteData(wd[0]),
        .MemRead(rd[0]), .MemWrite(wr[0]), .Size(sz[0]), .Unsigned(uns[0]),
        .ReadData(rdat[0]), .Ready(rdy[0]), .Fault(flt[0]), .Busy(bsy[0])
    );

    dmem_ctrl #(.DEPTH(DEP_B), .LATENCY(LAT_B)) u_b (
        .clk(clk), .reset(rst[1]), .Address(addr[1]), .WriteData(wd[1]),
        .MemRead(rd[1]), .MemWrite(wr[1]), .Size(sz[1]), .Unsigned(uns[1]),
        .ReadData(rdat[1]), .Ready(rdy[1]), .Fault(flt[1]), .Busy(bsy[1])
    );

    function automatic int dep_f(input int i);
        return (i == 0) ? DEP_A : DEP_B;
    endfunction

    function automatic int lat_f(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    task automatic model_op(input int i, input logic r, input logic w, input logic [1:0] s,
                            input logic u, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] er, output logic ef);
        int nb;
        logic [63:0] mask;
        logic [31:0] val;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        ef = (r && w) || (s == 2'd3) || ((a % nb) != 0) || (a >= 32'(4 * dep_f(i)));
        er = 32'd0;
        if (!ef) begin
            if (w) begin
                for (int k = 0; k < nb; k++) mdl[i][a + k] = d[8*k +: 8];
            end else begin
                val = 32'd0;
                for (int k = 0; k < nb; k++) val = val | (32'(mdl[i][a + k]) << (8 * k));
                mask = (64'd1 << (8 * nb)) - 64'd1;
                if (!u && val[8*nb-1]) val = val | ~mask[31:0];
                er = val;
            end
        end
    endtask

    // Apply reset, check reset outputs, release and measure the sweep length.
    task automatic reset_sweep(input int i);
        int n;
        bit seen_rdy;
        @(negedge clk);
        rst[i] = 1'b1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bsy[i]), 32'd1);
        chk("rst_ready", 32'(rdy[i]), 32'd0);
        chk("rst_fault", 32'(flt[i]), 32'd0);
        chk("rst_rdata", rdat[i], 32'd0);
        for (int k = 0; k < 512; k++) mdl[i][k] = 8'd0;
        rst[i] = 1'b0;
        n = 0;
        seen_rdy = 1'b0;
        while (n < 4 * dep_f(i) + 10) begin
            @(posedge clk);
            n++;
            #1;
            if (rdy[i]) seen_rdy = 1'b1;
            if (!bsy[i]) break;
        end
        chk("busy_cycles", 32'(n), 32'(dep_f(i)));
        chk("sweep_no_ready", 32'(seen_rdy), 32'd0);
        @(negedge clk);
        chained[i] = 1'b0;
    endtask

    // Drop the request and let the DUT return to IDLE.
    task automatic settle(input int i);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        @(negedge clk);
        chained[i] = 1'b0;
    endtask

    // One access: called at a negedge; ends at the negedge where Ready is seen.
    task automatic acc(input int i, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        logic [31:0] er;
        logic ef;
        int n;
        int explat;
        rd[i] = r; wr[i] = w; sz[i] = s; uns[i] = u; addr[i] = a; wd[i] = d;
        explat = lat_f(i) + (chained[i] ? 3 : 2);
        model_op(i, r, w, s, u, a, d, er, ef);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[i] && n < 40);
        chk({tag, "_lat"}, 32'(n), 32'(explat));
        chk({tag, "_fault"}, 32'(flt[i]), 32'(ef));
        chk({tag, "_rdata"}, rdat[i], er);
        $display("txn %s inst=%0d addr=%h wdata=%h rdata=%h fault=%0b cycles=%0d",
                 tag, i, a, d, rdat[i], flt[i], n);
        chained[i] = 1'b1;
    endtask

    initial begin
        logic r, w, u;
        logic [1:0] s;
        logic [31:0] a, d;
        int nb;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'd0;
            uns[i] = 1'b0; addr[i] = 32'd0; wd[i] = 32'd0; chained[i] = 1'b0;
        end

        // 1: sweep length and a load from the last word
        reset_sweep(0);
        acc(0, 1, 0, 2'd2, 0, 32'h1FC, 32'd0, "lw_1fc");
        settle(0);

        // 2: word store then loads of every width from the same word
        acc(0, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, "sw_10");
        settle(0);
        acc(0, 1, 0, 2'd2, 0, 32'h10, 32'd0, "lw_10");
        acc(0, 1, 0, 2'd0, 0, 32'h11, 32'd0, "lb_11");
        acc(0, 1, 0, 2'd0, 1, 32'h11, 32'd0, "lbu_11");
        acc(0, 1, 0, 2'd1, 0, 32'h12, 32'd0, "lh_12");
        acc(0, 1, 0, 2'd1, 1, 32'h12, 32'd0, "lhu_12");

        // 3: partial stores
        acc(0, 0, 1, 2'd0, 0, 32'h13, 32'h00000055, "sb_13");
        acc(0, 1, 0, 2'd2, 0, 32'h10, 32'd0, "lw_10_b");
        acc(0, 0, 1, 2'd1, 0, 32'h10, 32'hFFFF1234, "sh_10");
        acc(0, 1, 0, 2'd2, 0, 32'h10, 32'd0, "lw_10_h");

        // 4: faults
        acc(0, 1, 0, 2'd2, 0, 32'h12, 32'd0, "f_lw_12");
        acc(0, 1, 0, 2'd1, 0, 32'h11, 32'd0, "f_lh_11");
        acc(0, 0, 1, 2'd2, 0, 32'h200, 32'hFFFFFFFF, "f_sw_200");
        acc(0, 1, 0, 2'd2, 0, 32'h0, 32'd0, "lw_0");
        acc(0, 1, 1, 2'd2, 0, 32'h10, 32'h11111111, "f_rdwr");
        acc(0, 1, 0, 2'd3, 0, 32'h10, 32'd0, "f_size3");
        acc(0, 1, 0, 2'd2, 0, 32'h1FC, 32'd0, "lw_1fc_b");
        settle(0);

        // 5: reset while a store is in WAIT
        rd[0] = 1'b0; wr[0] = 1'b1; sz[0] = 2'd2; addr[0] = 32'h20; wd[0] = 32'hCAFEF00D;
        @(posedge clk);
        reset_sweep(0);
        acc(0, 1, 0, 2'd2, 0, 32'h20, 32'd0, "lw_20_rst");
        settle(0);

        // 6: zero-latency instance, requests held back to back
        reset_sweep(1);
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            a = 32'(4 * $urandom_range(0, DEP_B - 1));
            acc(1, 0, 1, 2'd2, 0, a, d, "b2b_sw");
            acc(1, 1, 0, 2'd2, 0, a, 32'd0, "b2b_lw");
        end
        acc(1, 1, 0, 2'd2, 0, 32'h3C, 32'd0, "b_lw_3c");
        acc(1, 0, 1, 2'd2, 0, 32'h40, 32'h5A5A5A5A, "b_f_sw_40");
        settle(1);

        // random mix on both instances
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 80; k++) begin
                r = ($urandom_range(0, 1) == 1);
                w = !r;
                if ($urandom_range(0, 9) == 0) begin
                    r = 1'b1;
                    w = 1'b1;
                end
                s = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                u = 1'($urandom_range(0, 1));
                d = $urandom;
                nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
                a = 32'($urandom_range(0, 4 * dep_f(i) + 7));
                if ($urandom_range(0, 3) != 0) a = a - (a % nb);
                acc(i, r, w, s, u, a, d, "rnd");
                if ($urandom_range(0, 2) == 0) settle(i);
            end
            settle(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, byte-addressed data memory for the MIPS datapath.
- Supports byte, halfword and word access, with sign or zero extension on loads.
- Writes are clocked; access latency is programmable and handshaked with Ready.
- After every reset, a hardware sweep clears memory to zero.
- Alignment and range faults are detected and reported.
Sits between the core's load/store unit and local storage, for the multicycle and pipelined cores.

Parameters:
DEPTH, 128, number of 32-bit words; power of 2, >= 4
LATENCY, 1, extra wait cycles per access; legal range 0..15

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
Address  in  32  byte address
WriteData  in  32  store data, right-justified for byte/half stores
MemRead  in  1  load request
MemWrite  in  1  store request
Size  in  2  00 byte, 01 half, 10 word, 11 reserved
Unsigned  in  1  1 = zero-extend load, 0 = sign-extend load
ReadData  out  32  registered load result; 0 on stores and faults
Ready  out  1  one-cycle completion pulse
Fault  out  1  valid only with Ready; 1 = access rejected
Busy  out  1  high during the clear sweep

Behaviour:
- Reset (asynchronous):
  - state <= INIT, sweep index <= 0.
  - Ready = 0, Fault = 0, ReadData = 0, Busy = 1.
  - An in-flight access is dropped; memory is not written by it.
- INIT:
  - Each cycle writes 0 to word[index] and increments index.
  - After word DEPTH-1 is written, go to IDLE and drop Busy. Busy is high for exactly DEPTH cycles after reset release.
  - Requests are ignored (not sampled) during INIT.
- IDLE:
  - Samples MemRead|MemWrite on each edge. If set, latch Address, WriteData, Size, Unsigned, MemRead, MemWrite; load cnt = LATENCY; go to WAIT.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access (or fault), register ReadData/Fault, go to RESP.
- RESP:
  - Ready = 1 for exactly one cycle; next edge returns to IDLE.
  - Request inputs are ignored in RESP; the requester drops or changes its request after seeing Ready.
- Latency and throughput:
  - Request first sampled at edge E; Ready is high in the cycle after edge E+LATENCY+1, i.e. LATENCY+2 cycles after sampling.
  - Back-to-back throughput is one access per LATENCY+3 cycles.
- Fault conditions (evaluated on latched values):
  - MemRead and MemWrite both set.
  - Size == 11.
  - Half with Address[0] != 0.
  - Word with Address[1:0] != 0.
  - Address >= 4*DEPTH.
  - On fault: memory unchanged, ReadData = 0, Fault = 1 with Ready. Fault latency is identical to a normal access.
- Indexing: word index = Address[log2(DEPTH)+1:2]; lane = Address[1:0].
- Stores:
  - Byte: WriteData[7:0] into lane, other bytes kept.
  - Half: WriteData[15:0] into bytes {Address[1],0} and {Address[1],1}.
  - Word: full replace.
  - ReadData = 0.
- Loads:
  - Extract the addressed byte or half.
  - Unsigned = 1: zero-extend to 32 bits. Unsigned = 0: replicate the top bit of the extracted field.
- Byte order is little-endian: lane 0 = bits 7:0.
- Ready and Fault are 0 in all states except RESP.
- ReadData holds its value until the next RESP or reset.

Test Plan:
1. Reset then release with DEPTH=128 -> Busy high exactly 128 cycles. Then lw 0x1FC -> ReadData = 0x00000000, Fault = 0.
2. LATENCY=2: sw 0xDEADBEEF @0x10 -> Ready 4 cycles after sampling. Loads from the same word:
   - lw 0x10 -> 0xDEADBEEF
   - lb 0x11 -> 0xFFFFFFBE
   - lbu 0x11 -> 0x000000BE
   - lh 0x12 -> 0xFFFFDEAD
   - lhu 0x12 -> 0x0000DEAD
3. Partial stores after scenario 2:
   - sb 0x55 @0x13, then lw 0x10 -> 0x55ADBEEF.
   - sh 0x1234 @0x10, then lw 0x10 -> 0x55AD1234.
4. Faults, each -> Ready with Fault = 1, ReadData = 0:
   - lw 0x12
   - lh 0x11
   - sw 0xFFFFFFFF @0x200 (then lw 0x0 -> unchanged)
   - MemRead and MemWrite both set
   - Size = 11
5. sw 0xCAFEF00D @0x20, reset asserted in WAIT -> Busy sweep restarts, no Ready pulse. Afterwards lw 0x20 -> 0x00000000.
6. LATENCY=0 instance: back-to-back sw/lw held continuously -> Ready 2 cycles after sampling, one pulse every 3 cycles, read data correct.
